// File: rtl/texture_mapper_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : texture_mapper_ram_port_arbiter
// Round-robin arbiter sharing one texture RAM port; routes read data back
// to the requester that issued the read.
// Rev    : 1.0
// ============================================================================
module texture_mapper_ram_port_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int RAM_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clken,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         ram_address,
  output logic                      ram_write_en,
  output logic                      ram_read_en,
  output logic [DATA_W-1:0]         ram_write_data,
  input  logic [DATA_W-1:0]         ram_read_data,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      busy
);

  localparam logic [ID_W-1:0] PTR_RESET = ID_W'(NUM_REQ - 1);

  logic                   active;
  logic [ID_W-1:0]        ptr;
  logic                   grant_found;
  logic [ID_W-1:0]        grant_id;
  logic                   accept_read;
  logic [RAM_LATENCY-1:0] pipe_valid;
  logic [ID_W-1:0]        pipe_id [RAM_LATENCY];

  assign active = clken & ~reset;

  // Scan from farthest to nearest so the nearest valid requester after ptr wins.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  always_comb begin
    req_ready      = '0;
    ram_address    = '0;
    ram_write_en   = 1'b0;
    ram_read_en    = 1'b0;
    ram_write_data = '0;
    if (active && grant_found) begin
      req_ready[grant_id] = 1'b1;
      ram_address         = req_addr[grant_id*ADDR_W +: ADDR_W];
      ram_write_data      = req_wdata[grant_id*DATA_W +: DATA_W];
      ram_write_en        = req_write[grant_id];
      ram_read_en         = ~req_write[grant_id];
    end
  end

  assign accept_read = ram_read_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= PTR_RESET;
    end else if (clken && grant_found) begin
      ptr <= grant_id;
    end
  end

  // In-flight read tracker: one stage per RAM latency cycle, frozen by clken.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_valid <= '0;
      for (int i = 0; i < RAM_LATENCY; i++) pipe_id[i] <= '0;
    end else if (clken) begin
      pipe_valid[0] <= accept_read;
      pipe_id[0]    <= grant_id;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_id[i]    <= pipe_id[i-1];
      end
    end
  end

  always_comb begin
    resp_valid = '0;
    if (pipe_valid[RAM_LATENCY-1]) resp_valid[pipe_id[RAM_LATENCY-1]] = 1'b1;
  end

  assign resp_data = ram_read_data;
  assign busy      = |pipe_valid;

endmodule
`default_nettype wire

// File: tb/tb_texture_mapper_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_texture_mapper_ram_port_arbiter
// Directed and random bench with a RAM model and a transaction-level reference.
// Rev    : 1.0
// ============================================================================
module tb_texture_mapper_ram_port_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int L  = 2;

  logic            clk = 1'b0;
  logic            reset, clken, preload_req;
  logic [N-1:0]    req_valid, req_write, req_ready, resp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [AW-1:0]   ram_address;
  logic            ram_write_en, ram_read_en, busy;
  logic [DW-1:0]   ram_write_data, ram_read_data, resp_data;

  texture_mapper_ram_port_arbiter #(
    .NUM_REQ(N), .ID_W(IW), .ADDR_W(AW), .DATA_W(DW), .RAM_LATENCY(L)
  ) dut (
    .clk(clk), .reset(reset), .clken(clken),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .ram_address(ram_address), .ram_write_en(ram_write_en),
    .ram_read_en(ram_read_en), .ram_write_data(ram_write_data),
    .ram_read_data(ram_read_data), .resp_valid(resp_valid),
    .resp_data(resp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pre(input int i);
    return 32'hA5A5_0000 ^ DW'(i * 32'h0001_0003);
  endfunction

  // RAM with L-cycle registered read, write-before-read across cycles
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] rd0, rd1;
  always @(posedge clk) begin
    if (preload_req) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pre(i);
    end else if (clken) begin
      if (ram_write_en) mem[ram_address] <= ram_write_data;
      rd0 <= mem[ram_address];
      rd1 <= rd0;
    end
  end
  assign ram_read_data = rd1;

  // Reference model: pointer, memory image, list of pending reads
  typedef struct {
    int            id;
    logic [DW-1:0] data;
    int            rem;
  } pend_t;
  pend_t         q[$];
  int            mptr = N - 1;
  logic [DW-1:0] ref_mem [1024];
  int            nvec = 0;
  int            nerr = 0;
  logic [N-1:0]  last_ready, last_resp;
  logic [DW-1:0] last_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_grant();
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (mptr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic cycle();
    int            g;
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [N-1:0]  ev;
    logic [DW-1:0] ed;
    pend_t         nq[$];
    @(negedge clk);
    g = (reset || !clken) ? -1 : exp_grant();
    w = 1'b0; a = '0; d = '0;
    if (g >= 0) begin
      w = req_write[g];
      a = req_addr[g*AW +: AW];
      d = req_wdata[g*DW +: DW];
    end
    chk("req_ready", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
    chk("ram_write_en", ram_write_en, (g >= 0) && w);
    chk("ram_read_en", ram_read_en, (g >= 0) && !w);
    if (g >= 0) chk("ram_address", ram_address, a);
    if (g >= 0 && w) chk("ram_write_data", ram_write_data, d);
    ev = '0; ed = '0;
    foreach (q[i]) if (q[i].rem == 0) begin ev = N'(1 << q[i].id); ed = q[i].data; end
    chk("resp_valid", resp_valid, ev);
    if (ev != 0) chk("resp_data", resp_data, ed);
    chk("busy", busy, q.size() != 0);
    last_ready = req_ready; last_resp = resp_valid; last_data = resp_data;
    @(posedge clk);
    if (reset) begin
      mptr = N - 1;
      q.delete();
    end else if (clken) begin
      foreach (q[i]) if (q[i].rem != 0) begin
        pend_t e;
        e = q[i];
        e.rem--;
        nq.push_back(e);
      end
      q = nq;
      if (g >= 0) begin
        mptr = g;
        if (w) ref_mem[a] = d;
        else   q.push_back('{g, ref_mem[a], L - 1});
      end
    end
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = v;
    req_write[i] = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  initial begin
    int cnt, at;
    for (int i = 0; i < 1024; i++) ref_mem[i] = pre(i);
    preload_req = 1'b1; reset = 1'b1; clken = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    cycle();
    preload_req = 1'b0;
    cycle();
    reset = 1'b0;
    cycle();
    chk("reset_resp", last_resp, 0);

    // All four read, addr i*16: order 0,1,2,3,0 and responses two cycles later
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, AW'(i * 16), '0);
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (k < 5) chk("p1_order", last_ready, 64'd1 << (k % 4));
      if (k >= 2) begin
        chk("p1_resp", last_resp, 64'd1 << (k - 2));
        chk("p1_data", last_data, pre(16 * (k - 2)));
      end
    end
    req_valid = '0;
    repeat (3) cycle();

    // Sole requester 2
    set_req(2, 1'b1, 1'b0, 10'd100, '0);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 5) req_valid = '0;
      cycle();
      if (k < 5) chk("p2_ready", last_ready, 4'b0100);
      if (last_resp == 4'b0100) cnt++;
    end
    chk("p2_pulses", cnt, 5);

    // Write then read of the same address
    set_req(1, 1'b1, 1'b1, 10'd5, 32'hDEADBEEF);
    cycle();
    req_valid = '0;
    set_req(3, 1'b1, 1'b0, 10'd5, '0);
    cycle();
    req_valid = '0;
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      if (last_resp != 0) begin
        cnt++;
        chk("p3_id", last_resp, 4'b1000);
        chk("p3_data", last_data, 32'hDEADBEEF);
      end
    end
    chk("p3_pulses", cnt, 1);

    // Stall for 3 cycles right after a read grant
    set_req(0, 1'b1, 1'b0, 10'd7, '0);
    cycle();
    req_valid = '0;
    clken = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("p4_ready_stall", last_ready, 0);
      chk("p4_no_resp_stall", last_resp, 0);
    end
    clken = 1'b1;
    cnt = 0; at = -1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      if (last_resp != 0) begin
        cnt++; at = k;
        chk("p4_id", last_resp, 4'b0001);
        chk("p4_data", last_data, pre(7));
      end
    end
    chk("p4_pulses", cnt, 1);
    chk("p4_when", at, 1);

    // Reset with reads in flight
    set_req(1, 1'b1, 1'b0, 10'd20, '0);
    set_req(2, 1'b1, 1'b0, 10'd21, '0);
    repeat (2) cycle();
    req_valid = '0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    chk("p5_resp", last_resp, 0);
    chk("p5_busy", busy, 0);
    req_valid = 4'b1111;
    cycle();
    chk("p5_first", last_ready, 4'b0001);

    // Requesters 0 and 3 alternate starting with 3
    req_valid = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("p6_alt", last_ready, (k % 2 == 0) ? 4'b1000 : 4'b0001);
    end
    req_valid = '0;
    repeat (3) cycle();

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      reset = ($urandom_range(0, 49) == 0);
      clken = ($urandom_range(0, 7) != 0);
      for (int i = 0; i < N; i++)
        set_req(i, 1'($urandom), 1'($urandom_range(0, 2) == 0),
                AW'($urandom_range(0, 63)), $urandom);
      cycle();
    end
    reset = 1'b0; clken = 1'b1; req_valid = '0;
    repeat (4) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/texture_mapper_ram_port_arbiter.md
Name: texture_mapper_ram_port_arbiter

Overview:
- Round-robin arbiter that shares one port of a texture_mapper dual-port RAM between NUM_REQ requesters (texel fetch, line writer, etc.).
- Issues at most one access per enabled cycle to the RAM port.
- Tracks in-flight reads through the RAM's fixed read latency and returns each read result to the requester that issued it.
- Sits between HLS-generated requester logic and one RAM port (A or B).

Parameters:
- NUM_REQ, 4, number of requesters; range 2..8.
- ID_W, 2, requester index width; must equal clog2(NUM_REQ).
- ADDR_W, 10, RAM address width (widthad of the port).
- DATA_W, 32, RAM data width (width of the port).
- RAM_LATENCY, 1, read latency of the attached RAM in clken-qualified cycles; range 1..4.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- clken  in  1  global clock enable, shared with the RAM; when low, all state holds.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_write  in  NUM_REQ  per-requester: 1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- req_ready  out  NUM_REQ  one-hot grant; a request is accepted when req_valid[i] & req_ready[i].
- ram_address  out  ADDR_W  address to the RAM port.
- ram_write_en  out  1  write enable to the RAM port.
- ram_read_en  out  1  read enable to the RAM port.
- ram_write_data  out  DATA_W  write data to the RAM port.
- ram_read_data  in  DATA_W  read data from the RAM port.
- resp_valid  out  NUM_REQ  one-hot: read data for requester i is valid this cycle.
- resp_data  out  DATA_W  read data, shared by all requesters.
- busy  out  1  1 while any read is in flight.

Behaviour:
- Reset (synchronous, highest priority, independent of clken):
  - priority pointer set to NUM_REQ-1, so requester 0 wins first.
  - in-flight shift register cleared.
  - resp_valid=0, busy=0.
- req_ready, ram_address, ram_write_en, ram_read_en and ram_write_data are combinational from req_* and the pointer.
  - While reset=1 or clken=0: req_ready=0 and ram_write_en=ram_read_en=0.
- Grant rule:
  - grant = the first i with req_valid[i]=1, scanning (ptr+1) mod NUM_REQ upward with wrap.
  - At most one requester is granted per cycle.
  - ram_* outputs carry the granted requester's fields: ram_write_en=req_write[g], ram_read_en=~req_write[g].
  - With no request: address and data are don't-care (drive 0), both enables are 0.
- Pointer update: on clk with clken=1 and a grant, ptr <= g. With no grant, ptr holds.
  - Consequence: a sole active requester is granted every cycle.
  - Consequence: all requesters active gives the order 0,1,2,...,NUM_REQ-1,0.
- Requesters must hold req_* stable until accepted. The arbiter does not latch requests.
- Read tracking: shift register of RAM_LATENCY stages, each holding {valid, id}.
  - Advances only when clken=1.
  - Stage 0 loads {ram_read_en, g}.
  - resp_valid = onehot(id) of the last stage when its valid=1, else 0. Registered: it goes high exactly RAM_LATENCY clken cycles after the accepting edge.
  - resp_data = ram_read_data (pass-through, aligned with the RAM output).
- busy = OR of the stage valid bits.
- Writes create no response. A write to address X in cycle n followed by a read of X in cycle n+1 returns the new data, given the RAM's write-then-read timing.
- clken low mid-flight: the pointer, shift register and resp_valid all hold. The response is delayed by the stalled cycles and is never duplicated or lost.
- Reset mid-flight: in-flight reads are discarded; no resp_valid pulse follows the reset.
- Error condition: a requester asserting req_valid with the address out of range is not checked.

Test Plan:
- Reset, then req_valid=4'b1111, all reads, addr_i=i*16, RAM_LATENCY=2 -> grants in order 0,1,2,3,0 on successive cycles. resp_valid=0001 two cycles after the first grant, then 0010, 0100, 1000. resp_data = preloaded mem[0],mem[16],mem[32],mem[48].
- Only requester 2 requests for 5 cycles -> req_ready=0100 every cycle. ptr=2 throughout. 5 consecutive resp_valid=0100 pulses.
- Requester 1 writes 0xDEADBEEF to addr 5, then requester 3 reads addr 5 -> one write pulse, no response for the write. resp_valid=1000 with resp_data=0xDEADBEEF.
- Read issued, then clken=0 for 3 cycles immediately after the grant -> resp_valid asserts 3 cycles later than nominal. The pulse is single, with correct id and data. req_ready=0 while clken=0.
- Two reads in flight, then reset pulsed for 1 cycle -> no resp_valid afterward. busy=0 next cycle. The next request grants requester 0 first when all are valid.
- Requesters 0 and 3 valid, ptr=0 -> requester 3 granted, then 0, alternating. Requesters 1 and 2 are never granted.
